mulby255: RTL and testbench
===========================

// Module: mulby255
// PURPOSE
//  Multiplies a 32-bit unsigned operand Y by 255 and returns X = (Y*255) mod 2^32, plus an overflow flag.
//  Computes byte-serially as X = (Y<<8) - Y, using one 8-bit subtract-with-borrow stage per cycle.
//  It is the encode-side partner of the divide-by-255 unit: feeding X into that unit returns Y whenever ovf=0.
//  The operand is loaded, and the result returned, as two 16-bit halves over the same flag-driven 16-bit port.
// PARAMETERS
//  none (widths fixed: 16-bit port, 32-bit operand, 8-bit digits)
// PORTS
//  clk    in   1   rising-edge clock
//  rst_n  in   1   asynchronous active-low reset
//  x      in   16  operand half-word (MS half, then LS half)
//  flg1   in   1   start: leave IDLE
//  flg2   in   1   MS half final; advance to LS-half capture
//  flg3   in   1   MS result half consumed; present LS half
//  flg4   in   1   LS result half consumed; return to IDLE
//  y      out  16  result half-word
//  ovf    out  1   1 = true product >= 2^32 (bits 39:32 nonzero)
//  done   out  1   1 while in WR_HI or WR_LO (y holds a result half)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; y=0, ovf=0, done=0; operand, result and borrow regs =0. Takes effect
//   immediately from any state, including mid-compute. Resumes from IDLE on the first edge after release.
//  All state and register updates happen on posedge clk. Each transition takes effect on the same edge
//   that samples the flag.
//  IDLE  : y<=0, ovf<=0. flg1 -> RD_HI, else stay.
//  RD_HI : Y[31:16]<=x on every cycle in this state, including the exit cycle. flg2 -> RD_LO, else stay.
//  RD_LO : Y[15:0]<=x once; b<=0; -> C0 unconditionally.
//  C0    : Z0<=0-Y0-b, b<=borrow  -> C1      (Yi = Y[8i+7:8i])
//  C1    : Z1<=Y0-Y1-b, b<=borrow -> C2
//  C2    : Z2<=Y1-Y2-b, b<=borrow -> C3
//  C3    : Z3<=Y2-Y3-b, b<=borrow -> C4
//  C4    : ovf<=((Y3-b)!=0) -> WR_HI. Y3-b is never negative.
//  WR_HI : y<={Z3,Z2}; done=1. flg3 -> WR_LO, else stay.
//  WR_LO : y<={Z1,Z0}; done=1. flg4 -> IDLE, else stay. ovf holds until the next IDLE.
//  Arithmetic: all 8-bit, wraps mod 256. Borrow is 1 iff minuend < subtrahend + b.
//  Latency: the RD_LO edge is followed by 5 compute edges; y={Z3,Z2} is visible after the 6th edge.
//  Flags are ignored in states that do not test them. A flg1 held high in WR_LO is not acted on until IDLE.
//  done is decoded from the state register (registered, glitch-free). State encoding is 4 bits;
//   unused codes go to IDLE on the next edge.
// TESTING
//  T1 Y=0x00000001: x=0x0000 then 0x0001 -> WR_HI y=0x0000; WR_LO y=0x00FF; ovf=0; done=1 in both.
//  T2 Y=0x01010101 -> y=0xFFFF then 0xFFFF, ovf=0. Passing 0xFFFFFFFF into the divider returns 0x01010101.
//  T3 Y=0x01010102 -> y=0x0000 then 0x00FE, ovf=1. Y=0xFFFFFFFF -> y=0xFFFF then 0xFF01, ovf=1.
//  T4 Hold flg2=0 for 3 cycles with x changing -> last x before the flg2 edge is captured as the MS half.
//     Hold flg3=0 for 10 cycles -> y stays at the MS half.
//  T5 Assert rst_n=0 asynchronously in C2 -> y=0, ovf=0, done=0 with no clock edge.
//     After release, a full transaction with Y=0 gives y=0x0000, 0x0000, ovf=0.
//  T6 Random Y (1000 vectors): {MS,LS} == (Y*255)[31:0] and ovf == |(Y*255)[39:32].

Source files
------------

// File: rtl/mulby255.sv
// Byte-serial multiply-by-255: X = (Y << 8) - Y, one 8-bit subtract-with-borrow per cycle.
// Operand and result move as two 16-bit halves over a flag-handshaked port.
module mulby255 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] x_i,
  input  logic        flg1_i,
  input  logic        flg2_i,
  input  logic        flg3_i,
  input  logic        flg4_i,
  output logic [15:0] y_o,
  output logic        ovf_o,
  output logic        done_o
);

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StRdHi = 4'd1,
    StRdLo = 4'd2,
    StC0   = 4'd3,
    StC1   = 4'd4,
    StC2   = 4'd5,
    StC3   = 4'd6,
    StC4   = 4'd7,
    StWrHi = 4'd8,
    StWrLo = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] z_q, z_d;
  logic        b_q, b_d;
  logic [15:0] y_q, y_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic [7:0]  min_byte, sub_byte;
  logic [8:0]  diff;

  // Digit i of (Y<<8) is Y digit i-1, so each stage subtracts Y_i from Y_{i-1}.
  always_comb begin
    min_byte = 8'd0;
    sub_byte = 8'd0;
    case (state_q)
      StC0: begin
        min_byte = 8'd0;
        sub_byte = op_q[7:0];
      end
      StC1: begin
        min_byte = op_q[7:0];
        sub_byte = op_q[15:8];
      end
      StC2: begin
        min_byte = op_q[15:8];
        sub_byte = op_q[23:16];
      end
      StC3: begin
        min_byte = op_q[23:16];
        sub_byte = op_q[31:24];
      end
      default: begin
        min_byte = 8'd0;
        sub_byte = 8'd0;
      end
    endcase
  end

  // Bit 8 of the 9-bit difference is set exactly when the stage borrows.
  assign diff = {1'b0, min_byte} - {1'b0, sub_byte} - {8'd0, b_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    z_d     = z_q;
    b_d     = b_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        ovf_d = 1'b0;
        if (flg1_i) state_d = StRdHi;
      end
      StRdHi: begin
        op_d[31:16] = x_i;
        if (flg2_i) state_d = StRdLo;
      end
      StRdLo: begin
        op_d[15:0] = x_i;
        b_d        = 1'b0;
        state_d    = StC0;
      end
      StC0: begin
        z_d[7:0] = diff[7:0];
        b_d      = diff[8];
        state_d  = StC1;
      end
      StC1: begin
        z_d[15:8] = diff[7:0];
        b_d       = diff[8];
        state_d   = StC2;
      end
      StC2: begin
        z_d[23:16] = diff[7:0];
        b_d        = diff[8];
        state_d    = StC3;
      end
      StC3: begin
        z_d[31:24] = diff[7:0];
        b_d        = diff[8];
        state_d    = StC4;
      end
      StC4: begin
        // Top product byte is Y3 - b; it cannot underflow.
        ovf_d   = (op_q[31:24] - {7'd0, b_q}) != 8'd0;
        state_d = StWrHi;
      end
      StWrHi: begin
        if (flg3_i) state_d = StWrLo;
      end
      StWrLo: begin
        if (flg4_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // y and done are loaded from the next state so they line up with the state change.
  always_comb begin
    y_d = y_q;
    if (state_q == StIdle) y_d = 16'd0;
    if (state_d == StWrHi) y_d = z_q[31:16];
    if (state_d == StWrLo) y_d = z_q[15:0];
    done_d = (state_d == StWrHi) || (state_d == StWrLo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= 32'd0;
      z_q     <= 32'd0;
      b_q     <= 1'b0;
      y_q     <= 16'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      z_q     <= z_d;
      b_q     <= b_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign y_o    = y_q;
  assign ovf_o  = ovf_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_mulby255.sv
// Randomized bench for mulby255: a plain Y*255 model drives expectations that a
// negedge compare process checks on every cycle of each transaction phase.
module tb_mulby255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x;
  logic        flg1, flg2, flg3, flg4;
  logic [15:0] y;
  logic        ovf, done;

  mulby255 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x_i   (x),
    .flg1_i(flg1),
    .flg2_i(flg2),
    .flg3_i(flg3),
    .flg4_i(flg4),
    .y_o   (y),
    .ovf_o (ovf),
    .done_o(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef enum int {PhNone, PhBusy, PhHi, PhLo} phase_e;
  phase_e      phase = PhNone;
  logic [15:0] exp_hi, exp_lo;
  logic        exp_ovf;

  function automatic logic [39:0] model(input logic [31:0] yv);
    return 40'(yv) * 40'd255;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    case (phase)
      PhBusy: check("busy_outputs", {14'd0, y, ovf, done}, 32'd0);
      PhHi:   check("wr_hi", {14'd0, y, ovf, done}, {14'd0, exp_hi, exp_ovf, 1'b1});
      PhLo:   check("wr_lo", {14'd0, y, ovf, done}, {14'd0, exp_lo, exp_ovf, 1'b1});
      default: ;
    endcase
  end

  // Starts in IDLE at posedge+1; returns at posedge+1 with the DUT in C0.
  task automatic load(input logic [31:0] yv, input int hold2);
    flg1 = 1'b1;
    @(posedge clk); #1;
    flg1 = 1'b0;
    repeat (hold2) begin
      x = 16'($urandom);
      @(posedge clk); #1;
    end
    x = yv[31:16];
    flg2 = 1'b1;
    @(posedge clk); #1;
    flg2 = 1'b0;
    x = yv[15:0];
    @(posedge clk); #1;
    x = 16'($urandom);
  endtask

  task automatic txn(input logic [31:0] yv, input int hold2, input int hold3, input int hold4,
                     output logic [15:0] got_hi, output logic [15:0] got_lo,
                     output logic got_ovf);
    logic [39:0] p;
    int n;
    p       = model(yv);
    exp_hi  = p[31:16];
    exp_lo  = p[15:0];
    exp_ovf = |p[39:32];
    got_hi  = 16'hxxxx;
    got_lo  = 16'hxxxx;
    got_ovf = 1'bx;
    phase   = PhBusy;
    load(yv, hold2);
    n = 0;
    while (!done && n < 20) begin
      flg1 = 1'($urandom);
      flg3 = 1'($urandom);
      flg4 = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    flg1 = 1'b0;
    flg3 = 1'b0;
    flg4 = 1'b0;
    check("compute_latency", 32'(n), 32'd5);
    if (!done) begin
      phase = PhNone;
      return;
    end
    got_hi  = y;
    got_ovf = ovf;
    phase   = PhHi;
    repeat (hold3) begin
      flg1 = 1'($urandom);
      flg4 = 1'($urandom);
      @(posedge clk); #1;
    end
    flg1 = 1'b0;
    flg4 = 1'b0;
    flg3 = 1'b1;
    @(posedge clk); #1;
    flg3   = 1'b0;
    got_lo = y;
    phase  = PhLo;
    repeat (hold4) begin
      flg3 = 1'($urandom);
      @(posedge clk); #1;
    end
    flg3 = 1'b0;
    flg4 = 1'b1;
    @(posedge clk); #1;
    flg4  = 1'b0;
    phase = PhNone;
    @(posedge clk); #1;
    check("idle_after_txn", {14'd0, y, ovf, done}, 32'd0);
  endtask

  task automatic pin(input string name, input logic [31:0] yv,
                     input logic [15:0] hi, input logic [15:0] lo, input logic ov);
    logic [15:0] gh, gl;
    logic        go;
    txn(yv, 0, 0, 0, gh, gl, go);
    check({name, "_hi"}, {16'd0, gh}, {16'd0, hi});
    check({name, "_lo"}, {16'd0, gl}, {16'd0, lo});
    check({name, "_ovf"}, {31'd0, go}, {31'd0, ov});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] gh, gl;
    logic        go;
    logic [31:0] r;
    rst_n = 1'b0;
    x     = 16'd0;
    flg1  = 1'b0;
    flg2  = 1'b0;
    flg3  = 1'b0;
    flg4  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {14'd0, y, ovf, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    pin("t1", 32'h0000_0001, 16'h0000, 16'h00FF, 1'b0);
    pin("t2", 32'h0101_0101, 16'hFFFF, 16'hFFFF, 1'b0);
    pin("t3a", 32'h0101_0102, 16'h0000, 16'h00FE, 1'b1);
    pin("t3b", 32'hFFFF_FFFF, 16'hFFFF, 16'hFF01, 1'b1);

    // MS half taken from the last x before flg2; WR_HI held for 10 cycles.
    txn(32'h1234_5678, 3, 10, 2, gh, gl, go);
    check("t4_hi", {16'd0, gh}, 32'h0000_2222);
    check("t4_lo", {16'd0, gl}, 32'h0000_2188);
    check("t4_ovf", {31'd0, go}, 32'd1);

    // Async reset in C2: outputs clear without an edge and the machine stays idle.
    load(32'hFFFF_FFFF, 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_c2", {14'd0, y, ovf, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("t5_stays_idle", {14'd0, y, ovf, done}, 32'd0);
    end

    // Async reset while WR_HI shows a nonzero half with ovf set.
    load(32'hFFFF_FFFF, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t5_pre_rst_wrhi", {14'd0, y, ovf, done}, {14'd0, 16'hFFFF, 1'b1, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_wrhi", {14'd0, y, ovf, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pin("t5_zero", 32'h0000_0000, 16'h0000, 16'h0000, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0:       r = 32'hFFFF_FFFF;
        1:       r = 32'($urandom_range(0, 255));
        2:       r = {8'd0, 24'($urandom)};
        default: r = $urandom;
      endcase
      txn(r, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), gh, gl, go);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
